wg_launch_ctrl: RTL and testbench

Host-side kernel launch sequencer in front of the GPGPU_top host request/response port. It accepts one kernel descriptor at a time and issues one host_req per workgroup with consecutive wg_ids. It bounds the number of in-flight workgroups and retires completions from host_rsp, then signals kernel completion with a sticky error flag and a cycle count. It replaces hand-driven host stimulus and is the block the host bridge uses to launch kernels.

---
 rtl/wg_launch_ctrl.sv | 167 ++++++++++++++++
 tb/tb_wg_launch_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wg_launch_ctrl.sv
// Kernel launch sequencer: takes one descriptor, issues one host_req per workgroup with
// consecutive wg_ids, bounds outstanding workgroups and retires completions from host_rsp.
module wg_launch_ctrl #(
  parameter int WG_ID_W      = 32,
  parameter int ADDR_W       = 32,
  parameter int CFG_W        = 128,
  parameter int CNT_W        = 16,
  parameter int MAX_INFLIGHT = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               knl_valid_i,
  output logic               knl_ready_o,
  input  logic [CNT_W-1:0]   knl_num_wg_i,
  input  logic [WG_ID_W-1:0] knl_wg_base_i,
  input  logic [ADDR_W-1:0]  knl_start_pc_i,
  input  logic [ADDR_W-1:0]  knl_pds_base_i,
  input  logic [ADDR_W-1:0]  knl_csr_knl_i,
  input  logic [ADDR_W-1:0]  knl_gds_base_i,
  input  logic [CFG_W-1:0]   knl_cfg_i,
  input  logic               knl_abort_i,
  output logic               knl_done_o,
  output logic               knl_err_o,
  output logic [31:0]        knl_cycles_o,
  output logic               host_req_valid_o,
  input  logic               host_req_ready_i,
  output logic [WG_ID_W-1:0] host_req_wg_id_o,
  output logic [ADDR_W-1:0]  host_req_start_pc_o,
  output logic [ADDR_W-1:0]  host_req_pds_base_o,
  output logic [ADDR_W-1:0]  host_req_csr_knl_o,
  output logic [ADDR_W-1:0]  host_req_gds_base_o,
  output logic [CFG_W-1:0]   host_req_cfg_o,
  input  logic               host_rsp_valid_i,
  output logic               host_rsp_ready_o,
  input  logic [WG_ID_W-1:0] host_rsp_wg_id_i
);

  localparam int CMP_W = (WG_ID_W > CNT_W) ? WG_ID_W : CNT_W;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   issued_reg, issued_next;
  logic [CNT_W-1:0]   retired_reg, retired_next;
  logic [CNT_W-1:0]   inflight_reg, inflight_next;
  logic [31:0]        cycles_reg, cycles_next;
  logic               err_reg, err_next;
  logic               aborted_reg, aborted_next;

  logic [CNT_W-1:0]   num_wg_reg;
  logic [WG_ID_W-1:0] base_reg;
  logic [WG_ID_W-1:0] wg_id_reg;
  logic [ADDR_W-1:0]  start_pc_reg, pds_base_reg, csr_knl_reg, gds_base_reg;
  logic [CFG_W-1:0]   cfg_reg;

  logic               accept, req_fire, rsp_fire, rsp_ok, in_range;
  logic [CMP_W-1:0]   rsp_off, num_wg_ext;

  assign accept           = (state_reg == IDLE) && knl_valid_i;
  assign host_req_valid_o = (state_reg == ISSUE) && (issued_reg < num_wg_reg) &&
                            (inflight_reg < CNT_W'(MAX_INFLIGHT));
  assign host_rsp_ready_o = (state_reg == ISSUE) || (state_reg == DRAIN);
  assign req_fire         = host_req_valid_o && host_req_ready_i;
  assign rsp_fire         = host_rsp_ready_o && host_rsp_valid_i;

  // Offset from base modulo 2^WG_ID_W, so a kernel whose ids wrap past zero still matches.
  assign rsp_off    = CMP_W'(host_rsp_wg_id_i - base_reg);
  assign num_wg_ext = CMP_W'(num_wg_reg);
  assign in_range   = rsp_off < num_wg_ext;
  assign rsp_ok     = rsp_fire && in_range && (inflight_reg != '0);

  assign knl_ready_o         = (state_reg == IDLE);
  assign knl_done_o          = (state_reg == DONE);
  assign knl_err_o           = err_reg;
  assign knl_cycles_o        = cycles_reg;
  assign host_req_wg_id_o    = wg_id_reg;
  assign host_req_start_pc_o = start_pc_reg;
  assign host_req_pds_base_o = pds_base_reg;
  assign host_req_csr_knl_o  = csr_knl_reg;
  assign host_req_gds_base_o = gds_base_reg;
  assign host_req_cfg_o      = cfg_reg;

  always_comb begin
    state_next    = state_reg;
    issued_next   = issued_reg;
    retired_next  = retired_reg;
    inflight_next = inflight_reg;
    cycles_next   = cycles_reg;
    err_next      = err_reg;
    aborted_next  = aborted_reg;
    case (state_reg)
      IDLE: begin
        if (knl_valid_i) begin
          issued_next   = '0;
          retired_next  = '0;
          inflight_next = '0;
          cycles_next   = '0;
          err_next      = 1'b0;
          aborted_next  = 1'b0;
          state_next    = (knl_num_wg_i == '0) ? DONE : ISSUE;
        end
      end
      ISSUE, DRAIN: begin
        if (cycles_reg != '1) cycles_next = cycles_reg + 32'd1;
        if (req_fire) issued_next = issued_reg + CNT_W'(1);
        if (rsp_ok) retired_next = retired_reg + CNT_W'(1);
        if (req_fire && !rsp_ok) inflight_next = inflight_reg + CNT_W'(1);
        else if (!req_fire && rsp_ok) inflight_next = inflight_reg - CNT_W'(1);
        if (rsp_fire && !rsp_ok) err_next = 1'b1;
        if (knl_abort_i) begin
          aborted_next = 1'b1;
          err_next     = 1'b1;
        end
        // Decide on next-cycle counts so the final response pulses done one cycle later.
        if (state_reg == ISSUE) begin
          if ((issued_next == num_wg_reg) || knl_abort_i) state_next = DRAIN;
        end else if ((inflight_next == '0) &&
                     ((retired_next == num_wg_reg) || aborted_next)) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      issued_reg   <= '0;
      retired_reg  <= '0;
      inflight_reg <= '0;
      cycles_reg   <= '0;
      err_reg      <= 1'b0;
      aborted_reg  <= 1'b0;
      num_wg_reg   <= '0;
      base_reg     <= '0;
      wg_id_reg    <= '0;
      start_pc_reg <= '0;
      pds_base_reg <= '0;
      csr_knl_reg  <= '0;
      gds_base_reg <= '0;
      cfg_reg      <= '0;
    end else begin
      state_reg    <= state_next;
      issued_reg   <= issued_next;
      retired_reg  <= retired_next;
      inflight_reg <= inflight_next;
      cycles_reg   <= cycles_next;
      err_reg      <= err_next;
      aborted_reg  <= aborted_next;
      if (accept) begin
        num_wg_reg   <= knl_num_wg_i;
        base_reg     <= knl_wg_base_i;
        wg_id_reg    <= knl_wg_base_i;
        start_pc_reg <= knl_start_pc_i;
        pds_base_reg <= knl_pds_base_i;
        csr_knl_reg  <= knl_csr_knl_i;
        gds_base_reg <= knl_gds_base_i;
        cfg_reg      <= knl_cfg_i;
      end else if (req_fire) begin
        wg_id_reg <= wg_id_reg + WG_ID_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_wg_launch_ctrl.sv
// Directed bench for wg_launch_ctrl: stimulus pushes expected requests/completions into
// queues; a negedge monitor pops and compares whenever the DUT hands over a req or done.
module tb_wg_launch_ctrl;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         knl_valid_i = 1'b0;
  logic         knl_ready_o;
  logic [15:0]  knl_num_wg_i = '0;
  logic [31:0]  knl_wg_base_i = '0;
  logic [31:0]  knl_start_pc_i = '0, knl_pds_base_i = '0, knl_csr_knl_i = '0, knl_gds_base_i = '0;
  logic [127:0] knl_cfg_i = '0;
  logic         knl_abort_i = 1'b0;
  logic         knl_done_o, knl_err_o;
  logic [31:0]  knl_cycles_o;
  logic         host_req_valid_o;
  logic         host_req_ready_i = 1'b0;
  logic [31:0]  host_req_wg_id_o;
  logic [31:0]  host_req_start_pc_o, host_req_pds_base_o, host_req_csr_knl_o, host_req_gds_base_o;
  logic [127:0] host_req_cfg_o;
  logic         host_rsp_valid_i = 1'b0;
  logic         host_rsp_ready_o;
  logic [31:0]  host_rsp_wg_id_i = '0;

  wg_launch_ctrl dut (
    .clk(clk), .rst(rst),
    .knl_valid_i(knl_valid_i), .knl_ready_o(knl_ready_o),
    .knl_num_wg_i(knl_num_wg_i), .knl_wg_base_i(knl_wg_base_i),
    .knl_start_pc_i(knl_start_pc_i), .knl_pds_base_i(knl_pds_base_i),
    .knl_csr_knl_i(knl_csr_knl_i), .knl_gds_base_i(knl_gds_base_i),
    .knl_cfg_i(knl_cfg_i), .knl_abort_i(knl_abort_i),
    .knl_done_o(knl_done_o), .knl_err_o(knl_err_o), .knl_cycles_o(knl_cycles_o),
    .host_req_valid_o(host_req_valid_o), .host_req_ready_i(host_req_ready_i),
    .host_req_wg_id_o(host_req_wg_id_o),
    .host_req_start_pc_o(host_req_start_pc_o), .host_req_pds_base_o(host_req_pds_base_o),
    .host_req_csr_knl_o(host_req_csr_knl_o), .host_req_gds_base_o(host_req_gds_base_o),
    .host_req_cfg_o(host_req_cfg_o),
    .host_rsp_valid_i(host_rsp_valid_i), .host_rsp_ready_o(host_rsp_ready_o),
    .host_rsp_wg_id_i(host_rsp_wg_id_i)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [31:0] wg_id; int cyc; } req_exp_t;
  typedef struct { logic err; int cyc; longint cycles; } done_exp_t;

  req_exp_t  exp_req_q[$];
  done_exp_t exp_done_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int acc_cyc  = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_req(input logic [31:0] id, input int c);
    req_exp_t e;
    e.wg_id = id;
    e.cyc   = c;
    exp_req_q.push_back(e);
  endtask

  task automatic push_done(input logic err, input int c, input longint cycles);
    done_exp_t e;
    e.err    = err;
    e.cyc    = c;
    e.cycles = cycles;
    exp_done_q.push_back(e);
  endtask

  task automatic rsp(input logic v, input logic [31:0] id);
    host_rsp_valid_i = v;
    host_rsp_wg_id_i = v ? id : 32'h0;
  endtask

  task automatic accept(input logic [15:0] num, input logic [31:0] base);
    check("accept_ready", {63'd0, knl_ready_o}, 64'd1);
    knl_num_wg_i   = num;
    knl_wg_base_i  = base;
    knl_start_pc_i = 32'hA000_0000 ^ base;
    knl_pds_base_i = 32'hB000_0000 ^ base;
    knl_csr_knl_i  = 32'hC000_0000 ^ base;
    knl_gds_base_i = 32'hD000_0000 ^ base;
    knl_cfg_i      = {4{base}};
    knl_valid_i    = 1'b1;
    acc_cyc        = cyc;
    tick();
    knl_valid_i    = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    int n = 0;
    while (exp_done_q.size() != 0 && n < bound) begin
      tick();
      n++;
    end
    check("done_within_bound", 64'(exp_done_q.size()), 64'd0);
    check("all_reqs_seen", 64'(exp_req_q.size()), 64'd0);
    exp_done_q.delete();
    exp_req_q.delete();
    tick();
  endtask

  // Monitor: sampled on the falling edge, away from the DUT's active edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (host_req_valid_o === 1'b1 && host_req_ready_i === 1'b1) begin
        $display("cycle %0d: req wg_id=0x%0h", cyc, host_req_wg_id_o);
        if (exp_req_q.size() == 0) begin
          n_checks++;
          $display("FAIL req_unexpected: got wg_id 0x%0h, want no request (cycle %0d)",
                   host_req_wg_id_o, cyc);
        end else begin
          req_exp_t e;
          e = exp_req_q.pop_front();
          check("req_wg_id", 64'(host_req_wg_id_o), 64'(e.wg_id));
          if (e.cyc >= 0) check("req_cycle", 64'(cyc), 64'(e.cyc));
        end
      end
      if (knl_done_o === 1'b1) begin
        $display("cycle %0d: done err=%0d cycles=%0d", cyc, knl_err_o, knl_cycles_o);
        if (exp_done_q.size() == 0) begin
          n_checks++;
          $display("FAIL done_unexpected: got done, want none (cycle %0d)", cyc);
        end else begin
          done_exp_t d;
          d = exp_done_q.pop_front();
          check("done_err", {63'd0, knl_err_o}, {63'd0, d.err});
          // Cycles spent in ISSUE/DRAIN: everything strictly between accept and done.
          check("done_cycles_interval", 64'(knl_cycles_o), 64'(cyc - acc_cyc - 1));
          if (d.cycles >= 0) check("done_cycles_const", 64'(knl_cycles_o), 64'(d.cycles));
          if (d.cyc >= 0) check("done_cycle", 64'(cyc), 64'(d.cyc));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int a, r;
    repeat (3) tick();
    rst = 1'b0;
    check("rst_ready", {63'd0, knl_ready_o}, 64'd1);
    check("rst_req_valid", {63'd0, host_req_valid_o}, 64'd0);
    check("rst_rsp_ready", {63'd0, host_rsp_ready_o}, 64'd0);
    check("rst_done", {63'd0, knl_done_o}, 64'd0);
    check("rst_cycles", 64'(knl_cycles_o), 64'd0);
    check("rst_cfg", 64'(host_req_cfg_o[63:0]), 64'd0);
    tick();

    // num_wg=4, base 0x10, ready always high, each rsp 5 cycles after its req.
    host_req_ready_i = 1'b1;
    a = cyc;
    for (int i = 0; i < 4; i++) push_req(32'h10 + i, a + 1 + i);
    push_done(1'b0, a + 10, 9);
    accept(16'd4, 32'h10);
    check("t1_start_pc", 64'(host_req_start_pc_o), 64'h0000_0000_A000_0010);
    check("t1_cfg", 64'(host_req_cfg_o[63:0]), 64'h0000_0010_0000_0010);
    while (cyc <= a + 11) begin
      if (cyc >= a + 6 && cyc <= a + 9) rsp(1'b1, 32'h10 + 32'(cyc - a - 6));
      else rsp(1'b0, 32'h0);
      if (cyc == a + 10) check("t1_ready_during_done", {63'd0, knl_ready_o}, 64'd0);
      if (cyc == a + 11) check("t1_ready_after_done", {63'd0, knl_ready_o}, 64'd1);
      tick();
    end
    rsp(1'b0, 32'h0);
    wait_done(20);

    // num_wg=20, rsps withheld: exactly 8 issue, then slot release and same-cycle handshakes.
    a = cyc;
    for (int i = 0; i < 8; i++) push_req(32'h100 + i, a + 1 + i);
    accept(16'd20, 32'h100);
    repeat (12) tick();
    check("t2_only_8_issued", 64'(exp_req_q.size()), 64'd0);
    r = cyc;
    push_req(32'h108, r + 1);
    push_req(32'h109, r + 3);
    push_req(32'h10A, r + 4);
    for (int i = 0; i < 9; i++) push_req(32'h10B + i, -1);
    push_done(1'b0, -1, -1);
    check("t2_stalled", {63'd0, host_req_valid_o}, 64'd0);
    rsp(1'b1, 32'h100); tick();
    rsp(1'b0, 32'h0);
    check("t2_slot_freed", {63'd0, host_req_valid_o}, 64'd1);
    tick();
    rsp(1'b1, 32'h101);
    check("t3_full_again", {63'd0, host_req_valid_o}, 64'd0);
    tick();
    rsp(1'b1, 32'h102);
    check("t3_at_7_valid", {63'd0, host_req_valid_o}, 64'd1);
    tick();
    rsp(1'b0, 32'h0);
    check("t3_inflight_held_7", {63'd0, host_req_valid_o}, 64'd1);
    tick();
    check("t3_full_after", {63'd0, host_req_valid_o}, 64'd0);
    for (int j = 0; j < 17; j++) begin
      rsp(1'b1, 32'h103 + j);
      tick();
    end
    rsp(1'b0, 32'h0);
    wait_done(30);

    // Wrapping base, one out-of-range rsp (base+num_wg) before the two good ones.
    a = cyc;
    push_req(32'hFFFF_FFFF, a + 1);
    push_req(32'h0000_0000, a + 2);
    push_done(1'b1, a + 6, 5);
    accept(16'd2, 32'hFFFF_FFFF);
    tick(); tick();
    rsp(1'b1, 32'h1); tick();
    rsp(1'b1, 32'hFFFF_FFFF); tick();
    rsp(1'b1, 32'h0); tick();
    rsp(1'b0, 32'h0);
    wait_done(20);

    // Empty kernel; also confirms err from the previous kernel is cleared on accept.
    a = cyc;
    push_done(1'b0, a + 1, 0);
    accept(16'd0, 32'h400);
    check("t4_rsp_ready_low", {63'd0, host_rsp_ready_o}, 64'd0);
    tick();
    check("t4_ready_back", {63'd0, knl_ready_o}, 64'd1);
    wait_done(10);

    // Abort in the cycle of the 3rd handshake: that req counts, nothing further issues.
    a = cyc;
    for (int i = 0; i < 3; i++) push_req(32'h200 + i, a + 1 + i);
    push_done(1'b1, a + 8, 7);
    accept(16'd10, 32'h200);
    tick(); tick();
    knl_abort_i = 1'b1; tick();
    knl_abort_i = 1'b0;
    check("t6_valid_after_abort", {63'd0, host_req_valid_o}, 64'd0);
    tick();
    rsp(1'b1, 32'h200); tick();
    rsp(1'b1, 32'h201); tick();
    rsp(1'b1, 32'h202); tick();
    rsp(1'b0, 32'h0);
    wait_done(20);

    // Reset in the middle of ISSUE.
    host_req_ready_i = 1'b0;
    accept(16'd5, 32'h300);
    check("t7_valid_pre_reset", {63'd0, host_req_valid_o}, 64'd1);
    tick();
    rst = 1'b1; tick();
    rst = 1'b0;
    check("t7_ready_after_rst", {63'd0, knl_ready_o}, 64'd1);
    check("t7_valid_after_rst", {63'd0, host_req_valid_o}, 64'd0);
    check("t7_rsp_ready_after_rst", {63'd0, host_rsp_ready_o}, 64'd0);
    check("t7_wg_id_after_rst", 64'(host_req_wg_id_o), 64'd0);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
